spike_encoder: RTL and testbench



---
 rtl/spike_encoder.sv | 176 +++++++++++++++++
 tb/tb_spike_encoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
// Character-to-spike encoder: each accepted ASCII character becomes a fixed-length
// burst of its 4-bit spike pattern on the HNSN ext_spike_in bus, followed by a silent gap.
module spike_encoder #(
    parameter logic [4:0] WINDOW_SIZE  = 5'd16,
    parameter logic [3:0] SPIKE_PERIOD = 4'd2,
    parameter logic [4:0] GAP_CYCLES   = 5'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] char_in,
    input  logic       char_in_valid,
    output logic       char_in_ready,
    input  logic       abort,
    output logic [3:0] spike_out,
    output logic [7:0] active_char,
    output logic       busy,
    output logic       char_done,
    output logic       char_err
);

    if (WINDOW_SIZE == 5'd0) begin : g_bad_window
        $error("spike_encoder: WINDOW_SIZE must be at least 1");
    end
    if (SPIKE_PERIOD == 4'd0) begin : g_bad_period
        $error("spike_encoder: SPIKE_PERIOD must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [4:0] win_r, win_s;
    logic [3:0] phase_r, phase_s;
    logic [4:0] gap_r, gap_s;
    logic [3:0] pattern_r, pattern_s;
    logic [3:0] spike_s;
    logic [7:0] active_s;
    logic       ready_s, busy_s, done_s, err_s;
    logic [4:0] map_s;

    // Returns {mapped, pattern}; lower-case a..f fold onto A..F.
    function automatic logic [4:0] map_char(input logic [7:0] c);
        logic [4:0] r;
        case (c)
            8'h41, 8'h61: r = 5'b1_0011;
            8'h42, 8'h62: r = 5'b1_1100;
            8'h43, 8'h63: r = 5'b1_0101;
            8'h44, 8'h64: r = 5'b1_1010;
            8'h45, 8'h65: r = 5'b1_1001;
            8'h46, 8'h66: r = 5'b1_0110;
            8'h20:        r = 5'b1_0000;
            default:      r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic; outputs are registered one cycle later.
    always_comb begin
        state_s   = state_r;
        win_s     = win_r;
        phase_s   = phase_r;
        gap_s     = gap_r;
        pattern_s = pattern_r;
        spike_s   = 4'b0000;
        active_s  = active_char;
        ready_s   = char_in_ready;
        busy_s    = busy;
        done_s    = 1'b0;
        err_s     = 1'b0;
        map_s     = map_char(char_in);

        if (abort && (state_r != IDLE)) begin
            state_s  = IDLE;
            win_s    = 5'd0;
            phase_s  = 4'd0;
            gap_s    = 5'd0;
            active_s = 8'h00;
            ready_s  = 1'b1;
            busy_s   = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // abort on the accept edge drops the character
                    if (char_in_valid && char_in_ready && !abort) begin
                        if (map_s[4]) begin
                            state_s   = BURST;
                            win_s     = 5'd0;
                            phase_s   = 4'd0;
                            pattern_s = map_s[3:0];
                            spike_s   = map_s[3:0];
                            active_s  = char_in;
                            ready_s   = 1'b0;
                            busy_s    = 1'b1;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                BURST: begin
                    if (win_r == (WINDOW_SIZE - 5'd1)) begin
                        if (GAP_CYCLES == 5'd0) begin
                            state_s  = IDLE;
                            active_s = 8'h00;
                            ready_s  = 1'b1;
                            busy_s   = 1'b0;
                            done_s   = 1'b1;
                        end else begin
                            state_s = GAP;
                            gap_s   = 5'd0;
                        end
                    end else begin
                        win_s = win_r + 5'd1;
                        if (phase_r == (SPIKE_PERIOD - 4'd1)) begin
                            phase_s = 4'd0;
                            spike_s = pattern_r;
                        end else begin
                            phase_s = phase_r + 4'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_r == (GAP_CYCLES - 5'd1)) begin
                        state_s  = IDLE;
                        active_s = 8'h00;
                        ready_s  = 1'b1;
                        busy_s   = 1'b0;
                        done_s   = 1'b1;
                    end else begin
                        gap_s = gap_r + 5'd1;
                    end
                end
                default: begin
                    state_s  = IDLE;
                    active_s = 8'h00;
                    ready_s  = 1'b1;
                    busy_s   = 1'b0;
                end
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            win_r         <= 5'd0;
            phase_r       <= 4'd0;
            gap_r         <= 5'd0;
            pattern_r     <= 4'b0000;
            spike_out     <= 4'b0000;
            active_char   <= 8'h00;
            char_in_ready <= 1'b1;
            busy          <= 1'b0;
            char_done     <= 1'b0;
            char_err      <= 1'b0;
        end else begin
            state_r       <= state_s;
            win_r         <= win_s;
            phase_r       <= phase_s;
            gap_r         <= gap_s;
            pattern_r     <= pattern_s;
            spike_out     <= spike_s;
            active_char   <= active_s;
            char_in_ready <= ready_s;
            busy          <= busy_s;
            char_done     <= done_s;
            char_err      <= err_s;
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Directed bench for spike_encoder: default instance plus a GAP_CYCLES=0 / SPIKE_PERIOD=3 instance.
module tb_spike_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] char_in, char_in2;
    logic       char_in_valid, char_in_valid2;
    logic       abort, abort2;
    logic       char_in_ready, char_in_ready2;
    logic [3:0] spike_out, spike_out2;
    logic [7:0] active_char, active_char2;
    logic       busy, busy2, char_done, char_done2, char_err, char_err2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spike_encoder dut (
        .clk(clk), .rst(rst), .char_in(char_in), .char_in_valid(char_in_valid),
        .char_in_ready(char_in_ready), .abort(abort), .spike_out(spike_out),
        .active_char(active_char), .busy(busy), .char_done(char_done), .char_err(char_err)
    );

    spike_encoder #(.WINDOW_SIZE(5'd16), .SPIKE_PERIOD(4'd3), .GAP_CYCLES(5'd0)) dut2 (
        .clk(clk), .rst(rst), .char_in(char_in2), .char_in_valid(char_in_valid2),
        .char_in_ready(char_in_ready2), .abort(abort2), .spike_out(spike_out2),
        .active_char(active_char2), .busy(busy2), .char_done(char_done2), .char_err(char_err2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called while window index 0 is visible; walks burst, gap and the completion cycle.
    task automatic expect_char(input bit alt, input logic [3:0] pat, input logic [7:0] ch,
                               input int per, input int gap, input string tag);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_spike_k%0d", tag, k), alt ? spike_out2 : spike_out,
                  ((k % per) == 0) ? pat : 4'b0000);
            check($sformatf("%s_busy_k%0d", tag, k), alt ? busy2 : busy, 1'b1);
            check($sformatf("%s_ready_k%0d", tag, k), alt ? char_in_ready2 : char_in_ready, 1'b0);
            check($sformatf("%s_active_k%0d", tag, k), alt ? active_char2 : active_char, ch);
            check($sformatf("%s_done_k%0d", tag, k), alt ? char_done2 : char_done, 1'b0);
            tick();
        end
        for (int g = 0; g < gap; g++) begin
            check($sformatf("%s_gapspike_g%0d", tag, g), alt ? spike_out2 : spike_out, 4'b0000);
            check($sformatf("%s_gapbusy_g%0d", tag, g), alt ? busy2 : busy, 1'b1);
            check($sformatf("%s_gapready_g%0d", tag, g), alt ? char_in_ready2 : char_in_ready, 1'b0);
            check($sformatf("%s_gapdone_g%0d", tag, g), alt ? char_done2 : char_done, 1'b0);
            tick();
        end
        check($sformatf("%s_done", tag), alt ? char_done2 : char_done, 1'b1);
        check($sformatf("%s_end_ready", tag), alt ? char_in_ready2 : char_in_ready, 1'b1);
        check($sformatf("%s_end_busy", tag), alt ? busy2 : busy, 1'b0);
        check($sformatf("%s_end_spike", tag), alt ? spike_out2 : spike_out, 4'b0000);
        check($sformatf("%s_end_active", tag), alt ? active_char2 : active_char, 8'h00);
    endtask

    initial begin
        rst = 1'b1;
        char_in = 8'h00; char_in_valid = 1'b0; abort = 1'b0;
        char_in2 = 8'h00; char_in_valid2 = 1'b0; abort2 = 1'b0;
        tick();
        tick();
        check("rst_spike", spike_out, 4'b0000);
        check("rst_ready", char_in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_active", active_char, 8'h00);
        check("rst_done", char_done, 1'b0);
        check("rst_err", char_err, 1'b0);
        check("rst_ready2", char_in_ready2, 1'b1);
        rst = 1'b0;
        tick();

        // 'A' with valid for one cycle
        char_in = 8'h41; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        expect_char(1'b0, 4'b0011, 8'h41, 2, 8, "A");
        tick();
        check("A_done_clear", char_done, 1'b0);

        // 'c' then 'D' back-to-back with valid held high
        char_in = 8'h63; char_in_valid = 1'b1;
        tick();
        char_in = 8'h44;
        expect_char(1'b0, 4'b0101, 8'h63, 2, 8, "c");
        tick();
        char_in_valid = 1'b0;
        expect_char(1'b0, 4'b1010, 8'h44, 2, 8, "D");
        tick();

        // unmapped '#'
        char_in = 8'h23; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        check("hash_err", char_err, 1'b1);
        check("hash_spike", spike_out, 4'b0000);
        check("hash_busy", busy, 1'b0);
        check("hash_ready", char_in_ready, 1'b1);
        tick();
        check("hash_err_clear", char_err, 1'b0);
        check("hash_busy2", busy, 1'b0);

        // space: full-length silent burst
        char_in = 8'h20; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        expect_char(1'b0, 4'b0000, 8'h20, 2, 8, "space");
        tick();
        check("space_done_clear", char_done, 1'b0);

        // 'B' aborted at window index 5
        char_in = 8'h42; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        check("B_k0", spike_out, 4'b1100);
        for (int i = 0; i < 5; i++) tick();
        check("B_k5_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_spike", spike_out, 4'b0000);
        check("abort_ready", char_in_ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_active", active_char, 8'h00);
        for (int i = 0; i < 30; i++) begin
            check($sformatf("abort_nodone_%0d", i), char_done, 1'b0);
            tick();
        end
        char_in = 8'h45; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        expect_char(1'b0, 4'b1001, 8'h45, 2, 8, "E");
        tick();

        // 'F' with reset during gap cycle 3
        char_in = 8'h46; char_in_valid = 1'b1;
        tick();
        char_in_valid = 1'b0;
        check("F_k0", spike_out, 4'b0110);
        for (int i = 0; i < 19; i++) tick();
        check("F_gap3_busy", busy, 1'b1);
        check("F_gap3_ready", char_in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("F_rst_spike", spike_out, 4'b0000);
        check("F_rst_ready", char_in_ready, 1'b1);
        check("F_rst_busy", busy, 1'b0);
        check("F_rst_active", active_char, 8'h00);
        check("F_rst_done", char_done, 1'b0);
        check("F_rst_err", char_err, 1'b0);
        tick();

        // GAP_CYCLES=0, SPIKE_PERIOD=3 instance
        char_in2 = 8'h41; char_in_valid2 = 1'b1;
        tick();
        char_in_valid2 = 1'b0;
        expect_char(1'b1, 4'b0011, 8'h41, 3, 0, "A_p3");
        tick();
        check("A_p3_done_clear", char_done2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
